// File: rtl/tsc_capture_sequencer.sv
// Trigger-surround capture controller: paces ADC conversions, fills a ring RAM,
// detects the trigger, collects post-trigger samples, then streams the ring out serially.
module tsc_capture_sequencer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned DEPTH_LOG2  = 5,
    parameter int unsigned PRE_SAMPLES = 16,
    parameter logic [7:0]  TRIGVL      = 8'hD5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  adc_req,
    input  logic                  adc_ack,
    input  logic [7:0]            adc_data,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  rd_en,
    output logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  trd,
    output logic                  cd,
    output logic [31:0]           trigtm,
    output logic                  sd,
    output logic                  sd_valid,
    output logic                  busy
);

    localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
    localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned STREAM_BITS = 8 * DEPTH;
    // readout cycle counter runs 0 .. STREAM_BITS+1
    localparam int unsigned RCNT_W      = DEPTH_LOG2 + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_READOUT,
        S_DONE
    } state_t;

    state_t                state, state_d;
    logic [DIV_W-1:0]      div, div_d;
    logic                  outst, outst_d;
    logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] cnt, cnt_d;
    logic [31:0]           timer, timer_d;
    logic                  trd_d;
    logic [31:0]           trigtm_d;
    logic [RCNT_W-1:0]     rcnt, rcnt_d;
    logic [6:0]            shreg, shreg_d;
    logic                  sd_d, sd_valid_d, cd_d, rd_en_d, busy_d;
    logic [DEPTH_LOG2-1:0] rd_addr_d;
    logic                  sampling, ack_ok, bit_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            div      <= '0;
            outst    <= 1'b0;
            wr_ptr   <= '0;
            cnt      <= '0;
            timer    <= '0;
            trd      <= 1'b0;
            trigtm   <= '0;
            rcnt     <= '0;
            shreg    <= '0;
            sd       <= 1'b0;
            sd_valid <= 1'b0;
            cd       <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            div      <= div_d;
            outst    <= outst_d;
            wr_ptr   <= wr_ptr_d;
            cnt      <= cnt_d;
            timer    <= timer_d;
            trd      <= trd_d;
            trigtm   <= trigtm_d;
            rcnt     <= rcnt_d;
            shreg    <= shreg_d;
            sd       <= sd_d;
            sd_valid <= sd_valid_d;
            cd       <= cd_d;
            rd_en    <= rd_en_d;
            rd_addr  <= rd_addr_d;
            busy     <= busy_d;
        end
    end

    // Next-state, sampling handshake, ring writes and serial readout
    always_comb begin
        state_d    = state;
        div_d      = div;
        outst_d    = outst;
        wr_ptr_d   = wr_ptr;
        cnt_d      = cnt;
        timer_d    = timer;
        trd_d      = trd;
        trigtm_d   = trigtm;
        rcnt_d     = '0;
        shreg_d    = shreg;
        sd_d       = 1'b0;
        sd_valid_d = 1'b0;
        cd_d       = 1'b0;
        bit_c      = 1'b0;
        adc_req    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        ack_ok     = 1'b0;
        sampling   = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);

        if (state != S_IDLE) begin
            timer_d = timer + 32'd1;
        end

        // Conversion pacing: one request per divider wrap, never two in flight
        if (sampling && !abort) begin
            div_d = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
            if ((div == '0) && !outst) begin
                adc_req = 1'b1;
                outst_d = 1'b1;
            end
            if (adc_ack && outst) begin
                ack_ok   = 1'b1;
                outst_d  = 1'b0;
                wr_en    = 1'b1;
                wr_addr  = wr_ptr;
                wr_data  = adc_data;
                wr_ptr_d = wr_ptr + DEPTH_LOG2'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    trd_d    = 1'b0;
                    trigtm_d = '0;
                    wr_ptr_d = '0;
                    timer_d  = '0;
                    div_d    = '0;
                    cnt_d    = '0;
                    outst_d  = 1'b0;
                    state_d  = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (ack_ok) begin
                    if (cnt == DEPTH_LOG2'(PRE_SAMPLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt + DEPTH_LOG2'(1);
                    end
                end
            end
            S_ARMED: begin
                if (ack_ok && (adc_data >= TRIGVL)) begin
                    trd_d    = 1'b1;
                    trigtm_d = timer;
                    cnt_d    = '0;
                    state_d  = S_POST;
                end
            end
            S_POST: begin
                if (ack_ok) begin
                    if (cnt == DEPTH_LOG2'(DEPTH - PRE_SAMPLES - 2)) begin
                        cnt_d   = '0;
                        state_d = S_READOUT;
                    end else begin
                        cnt_d = cnt + DEPTH_LOG2'(1);
                    end
                end
            end
            S_READOUT: begin
                // Byte fetched at rcnt%8==0 arrives at rcnt%8==1 and is loaded whole
                rcnt_d = rcnt + RCNT_W'(1);
                if (rcnt[2:0] == 3'd1) begin
                    bit_c   = rd_data[7];
                    shreg_d = rd_data[6:0];
                end else begin
                    bit_c   = shreg[6];
                    shreg_d = {shreg[5:0], 1'b0};
                end
                sd_valid_d = (rcnt != '0) && (rcnt <= RCNT_W'(STREAM_BITS));
                sd_d       = sd_valid_d & bit_c;
                if (rcnt == RCNT_W'(STREAM_BITS + 1)) begin
                    cd_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            outst_d    = 1'b0;
            trd_d      = 1'b0;
            sd_d       = 1'b0;
            sd_valid_d = 1'b0;
            cd_d       = 1'b0;
            rcnt_d     = '0;
        end

        rd_en_d   = (state_d == S_READOUT) && (rcnt_d[2:0] == 3'd0) &&
                    (rcnt_d < RCNT_W'(STREAM_BITS));
        rd_addr_d = rd_en_d ? wr_ptr_d + rcnt_d[RCNT_W-2:3] : '0;
        busy_d    = (state_d != S_IDLE);
    end

endmodule
